// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder/subtractor: WORDS*32-bit operands processed one 32-bit limb per
// cycle through a single shared add slice, with the carry held in a register between limbs.

module add_slice32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c,
    output logic [31:0] s,
    output logic        co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {32'd0, c};
endmodule

module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic                  op_sub,
    input  logic [32*WORDS-1:0]   a_in,
    input  logic [32*WORDS-1:0]   b_in,
    input  logic                  cin,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [32*WORDS-1:0]   res_sum,
    output logic                  res_cout,
    output logic                  res_ovf,
    output logic                  busy
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [WORDS-1:0][31:0]  op_a;
    logic [WORDS-1:0][31:0]  op_b;
    logic [WORDS-1:0][31:0]  sum_q;
    logic                    carry;
    logic [IW-1:0]           idx;
    logic [31:0]             slice_s;
    logic                    slice_c;

    add_slice32 u_slice (
        .a  (op_a[idx]),
        .b  (op_b[idx]),
        .c  (carry),
        .s  (slice_s),
        .co (slice_c)
    );

    assign res_sum     = sum_q;
    assign start_ready = rst_n && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_cout  <= 1'b0;
            res_ovf   <= 1'b0;
            busy      <= 1'b0;
            sum_q     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    // Subtraction is a + ~b + 1; the +1 rides in as the initial carry.
                    op_a  <= a_in;
                    op_b  <= op_sub ? ~b_in : b_in;
                    carry <= op_sub ? 1'b1 : cin;
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    sum_q[idx] <= slice_s;
                    carry      <= slice_c;
                    idx        <= idx + 1'b1;
                    if (idx == LAST) begin
                        res_cout  <= slice_c;
                        res_ovf   <= (op_a[WORDS-1][31] == op_b[WORDS-1][31]) &&
                                     (slice_s[31] != op_a[WORDS-1][31]);
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed plus randomized checks of wide_add_sequencer (WORDS=4 and WORDS=1 instances)
// against a full-width arithmetic reference model.

module tb_wide_add_sequencer;
    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0, op_sub = 1'b0, cin = 1'b0, res_ready = 1'b0;
    logic [W-1:0] a_in = '0, b_in = '0;
    logic         start_ready, res_valid, res_cout, res_ovf, busy;
    logic [W-1:0] res_sum;

    logic         sv1 = 1'b0, os1 = 1'b0, cin1 = 1'b0, rr1 = 1'b0;
    logic [31:0]  a1 = '0, b1 = '0;
    logic         sr1, rv1, rc1, ro1, busy1;
    logic [31:0]  rs1;

    int passed = 0, failed = 0, total = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .op_sub(op_sub), .a_in(a_in), .b_in(b_in), .cin(cin), .res_valid(res_valid),
        .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
        .busy(busy)
    );

    wide_add_sequencer #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
        .op_sub(os1), .a_in(a1), .b_in(b1), .cin(cin1), .res_valid(rv1),
        .res_ready(rr1), .res_sum(rs1), .res_cout(rc1), .res_ovf(ro1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {cout, ovf, sum}; overflow judged by whether the exact signed result fits W bits.
    function automatic logic [W+1:0] model(input logic sub, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic c);
        logic [W:0]   u;
        logic [W+1:0] sa, sb, t;
        logic         co;
        sa = {{2{a[W-1]}}, a};
        sb = {{2{b[W-1]}}, b};
        if (sub) begin
            u  = {1'b0, a} - {1'b0, b};
            co = (a >= b);
            t  = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b} + (W+1)'(c);
            co = u[W];
            t  = sa + sb + (W+2)'(c);
        end
        return {co, !(t[W+1] == t[W] && t[W] == t[W-1]), u[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c);
        int n = 0;
        while (!start_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("start_ready_idle", W'(start_ready), W'(1));
        start_valid = 1'b1; op_sub = sub; a_in = a; b_in = b; cin = c;
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!res_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("valid_after_handshake", W'(res_valid), W'(0));
        chk("busy_after_handshake", W'(busy), W'(0));
    endtask

    task automatic do_op(input string tag, input logic sub, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c);
        int lat;
        logic [W+1:0] m;
        m = model(sub, a, b, c);
        start_op(sub, a, b, c);
        wait_valid(lat);
        chk({tag, "_latency"}, W'(lat), W'(4));
        chk({tag, "_sum"}, res_sum, m[W-1:0]);
        chk({tag, "_cout"}, W'(res_cout), W'(m[W+1]));
        chk({tag, "_ovf"}, W'(res_ovf), W'(m[W]));
        drain();
    endtask

    initial begin
        int lat, hs;
        logic [W+1:0] m;
        logic [W-1:0] ra, rb;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", W'(res_valid), W'(0));
        chk("rst_sum", res_sum, '0);
        chk("rst_cout", W'(res_cout), W'(0));
        chk("rst_ovf", W'(res_ovf), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_start_ready", W'(start_ready), W'(0));
        chk("rst_valid_w1", W'(rv1), W'(0));
        rst_n = 1'b1;
        #1;
        chk("start_ready_after_rst", W'(start_ready), W'(1));

        // T1..T3 directed
        do_op("t1", 1'b0, 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0);
        do_op("t2", 1'b0, {W{1'b1}}, '0, 1'b1);
        do_op("t3a", 1'b1, '0, 128'h1, 1'b0);
        do_op("t3b", 1'b1, 128'h80000000_00000000_00000000_00000000, 128'h1, 1'b1);
        do_op("t3c", 1'b0, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0);

        // randomized ops
        for (int i = 0; i < 16; i++) begin
            ra = rnd128();
            rb = (i % 4 == 0) ? ~ra : rnd128();
            do_op("rnd", 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
        end

        // T4 backpressure
        ra = rnd128(); rb = rnd128();
        m = model(1'b0, ra, rb, 1'b1);
        start_op(1'b0, ra, rb, 1'b1);
        wait_valid(lat);
        chk("t4_latency", W'(lat), W'(4));
        for (int i = 0; i < 10; i++) begin
            start_valid = i[0];
            a_in = rnd128(); b_in = rnd128(); op_sub = 1'b1;
            @(posedge clk); #1;
            chk("t4_valid", W'(res_valid), W'(1));
            chk("t4_sum", res_sum, m[W-1:0]);
            chk("t4_cout", W'(res_cout), W'(m[W+1]));
            chk("t4_ovf", W'(res_ovf), W'(m[W]));
            chk("t4_start_ready", W'(start_ready), W'(0));
        end
        start_valid = 1'b0;
        drain();
        repeat (5) @(posedge clk);
        #1;
        chk("t4_no_ghost_valid", W'(res_valid), W'(0));
        chk("t4_no_ghost_busy", W'(busy), W'(0));

        // T5 reset mid-RUN
        start_op(1'b0, rnd128(), rnd128(), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_busy_mid_run", W'(busy), W'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t5_valid", W'(res_valid), W'(0));
        chk("t5_busy", W'(busy), W'(0));
        chk("t5_start_ready_in_rst", W'(start_ready), W'(0));
        rst_n = 1'b1;
        #1;
        chk("t5_start_ready", W'(start_ready), W'(1));
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_stale_result", W'(res_valid), W'(0));
        start_op(1'b0, 128'h5, 128'h7, 1'b0);
        wait_valid(lat);
        chk("t5_latency", W'(lat), W'(4));
        chk("t5_sum", res_sum, 128'h0000000C);
        chk("t5_cout", W'(res_cout), W'(0));
        drain();

        // T6 WORDS=1
        chk("t6_start_ready", W'(sr1), W'(1));
        sv1 = 1'b1; a1 = 32'hFFFFFFFF; b1 = 32'h1; cin1 = 1'b0; os1 = 1'b0;
        @(posedge clk); #1;
        sv1 = 1'b0;
        @(posedge clk); #1;
        chk("t6_valid_lat1", W'(rv1), W'(1));
        chk("t6_sum", W'(rs1), W'(0));
        chk("t6_cout", W'(rc1), W'(1));
        chk("t6_ovf", W'(ro1), W'(0));
        rr1 = 1'b1;
        @(posedge clk); #1;
        rr1 = 1'b0;
        chk("t6_valid_cleared", W'(rv1), W'(0));
        a1 = 32'h1; b1 = 32'h2; sv1 = 1'b1; rr1 = 1'b1;
        hs = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            chk("t6_b2b_valid", W'(rv1), W'(i % 3 == 1));
            if (rv1) begin
                hs++;
                chk("t6_b2b_sum", W'(rs1), W'(3));
            end
        end
        sv1 = 1'b0; rr1 = 1'b0;
        chk("t6_b2b_results", W'(hs), W'(3));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
